// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage with its IF/ID pipeline register.
//            Holds the PC and issues instruction-memory reads through a
//            ready handshake. It buffers a returned instruction when ID
//            cannot take it, applies flush-time redirects, and inserts
//            bubbles into ID.
// Ports    : clk, reset_n            - clock, async active-low reset
//            pc_write, ir_write      - PC / IF-ID update enables
//            stall_IFID, flush_IFID  - IF/ID hold / kill
//            redirect_valid/_pc      - corrected fetch address
//            i_readM, i_address      - instruction-memory request
//            i_data, i_ready         - instruction-memory response
//            inst_ID, pc_ID,
//            pc_plus1_ID, valid_ID   - IF/ID register contents
//            fetch_busy              - waiting on instruction memory
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                   WORD_SIZE   = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC    = '0,
    parameter logic [WORD_SIZE-1:0] BUBBLE_INST = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pc_write,
    input  logic                 ir_write,
    input  logic                 stall_IFID,
    input  logic                 flush_IFID,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_ready,
    output logic [WORD_SIZE-1:0] inst_ID,
    output logic [WORD_SIZE-1:0] pc_ID,
    output logic [WORD_SIZE-1:0] pc_plus1_ID,
    output logic                 valid_ID,
    output logic                 fetch_busy
);

    localparam logic [WORD_SIZE-1:0] c_one = {{(WORD_SIZE-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t               r_state,       w_state_nxt;
    logic [WORD_SIZE-1:0] r_pc,          w_pc_nxt;
    logic [WORD_SIZE-1:0] r_buf_inst,    w_buf_inst_nxt;
    logic [WORD_SIZE-1:0] r_buf_pc,      w_buf_pc_nxt;
    logic [WORD_SIZE-1:0] r_inst_id,     w_inst_id_nxt;
    logic [WORD_SIZE-1:0] r_pc_id,       w_pc_id_nxt;
    logic [WORD_SIZE-1:0] r_pc_plus1_id, w_pc_plus1_id_nxt;
    logic                 r_valid_id,    w_valid_id_nxt;

    logic w_accept;
    assign w_accept = ir_write & ~stall_IFID;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_buf_inst    <= '0;
            r_buf_pc      <= '0;
            r_inst_id     <= BUBBLE_INST;
            r_pc_id       <= '0;
            r_pc_plus1_id <= '0;
            r_valid_id    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_buf_inst    <= w_buf_inst_nxt;
            r_buf_pc      <= w_buf_pc_nxt;
            r_inst_id     <= w_inst_id_nxt;
            r_pc_id       <= w_pc_id_nxt;
            r_pc_plus1_id <= w_pc_plus1_id_nxt;
            r_valid_id    <= w_valid_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_buf_inst_nxt    = r_buf_inst;
        w_buf_pc_nxt      = r_buf_pc;
        w_inst_id_nxt     = r_inst_id;
        w_pc_id_nxt       = r_pc_id;
        w_pc_plus1_id_nxt = r_pc_plus1_id;
        w_valid_id_nxt    = r_valid_id;

        if (flush_IFID) begin
            // Flush wins over stall; same-cycle i_data and any buffered
            // instruction are dropped. Without a redirect the current PC is
            // simply fetched again.
            w_state_nxt    = S_FETCH;
            w_inst_id_nxt  = BUBBLE_INST;
            w_valid_id_nxt = 1'b0;
            if (redirect_valid && pc_write) begin
                w_pc_nxt = redirect_pc;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (i_ready) begin
                        if (w_accept) begin
                            w_inst_id_nxt     = i_data;
                            w_pc_id_nxt       = r_pc;
                            w_pc_plus1_id_nxt = r_pc + c_one;
                            w_valid_id_nxt    = 1'b1;
                            if (pc_write) begin
                                w_pc_nxt = r_pc + c_one;
                            end
                        end else begin
                            // ID is busy: park the word so the read is not lost.
                            w_buf_inst_nxt = i_data;
                            w_buf_pc_nxt   = r_pc;
                            w_state_nxt    = S_HOLD;
                        end
                    end else if (w_accept) begin
                        // Memory not ready but ID wants something: bubble.
                        w_inst_id_nxt  = BUBBLE_INST;
                        w_valid_id_nxt = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        w_inst_id_nxt     = r_buf_inst;
                        w_pc_id_nxt       = r_buf_pc;
                        w_pc_plus1_id_nxt = r_buf_pc + c_one;
                        w_valid_id_nxt    = 1'b1;
                        // Buffer is only released once the PC can move on.
                        if (pc_write) begin
                            w_pc_nxt    = r_pc + c_one;
                            w_state_nxt = S_FETCH;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_FETCH;
                end
            endcase
        end
    end

    // Request and busy are gated by reset_n so they drop the instant reset
    // is asserted, even though the state register already reads S_FETCH.
    assign i_readM     = reset_n & (r_state == S_FETCH);
    assign fetch_busy  = reset_n & (r_state == S_FETCH) & ~i_ready;
    assign i_address   = r_pc;
    assign inst_ID     = r_inst_id;
    assign pc_ID       = r_pc_id;
    assign pc_plus1_ID = r_pc_plus1_id;
    assign valid_ID    = r_valid_id;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage. Memory returns
//            i_data = i_address + 16'h1000; readiness is driven per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic        pc_write;
    logic        ir_write;
    logic        stall_IFID;
    logic        flush_IFID;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic [15:0] inst_ID;
    logic [15:0] pc_ID;
    logic [15:0] pc_plus1_ID;
    logic        valid_ID;
    logic        fetch_busy;

    int n_checks = 0;
    int n_fails  = 0;

    assign i_data = i_address + 16'h1000;

    fetch_stage #(
        .WORD_SIZE  (16),
        .RESET_PC   (16'h0000),
        .BUBBLE_INST(16'h0000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .stall_IFID    (stall_IFID),
        .flush_IFID    (flush_IFID),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .i_readM       (i_readM),
        .i_address     (i_address),
        .i_data        (i_data),
        .i_ready       (i_ready),
        .inst_ID       (inst_ID),
        .pc_ID         (pc_ID),
        .pc_plus1_ID   (pc_plus1_ID),
        .valid_ID      (valid_ID),
        .fetch_busy    (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic [15:0] inst, input logic [15:0] pc,
                            input logic vld);
        check_eq({tag, ".inst"}, inst_ID, inst);
        check_eq({tag, ".pc"}, pc_ID, pc);
        check_eq({tag, ".pc1"}, pc_plus1_ID, pc + 16'h0001);
        check_eq({tag, ".valid"}, {15'd0, valid_ID}, {15'd0, vld});
    endtask

    task automatic normal_inputs();
        pc_write       = 1'b1;
        ir_write       = 1'b1;
        stall_IFID     = 1'b0;
        flush_IFID     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        i_ready        = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        normal_inputs();
        #12;
        // Reset state
        check_eq("rst.readM", {15'd0, i_readM}, 16'h0000);
        check_eq("rst.inst", inst_ID, 16'h0000);
        check_eq("rst.pc", pc_ID, 16'h0000);
        check_eq("rst.pc1", pc_plus1_ID, 16'h0000);
        check_eq("rst.valid", {15'd0, valid_ID}, 16'h0000);
        check_eq("rst.addr", i_address, 16'h0000);
        check_eq("rst.busy", {15'd0, fetch_busy}, 16'h0000);

        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("rel.addr", i_address, 16'h0000);
        check_eq("rel.readM", {15'd0, i_readM}, 16'h0001);

        // Zero-wait streaming: one instruction per cycle, one cycle latency
        for (int k = 0; k < 5; k++) begin
            tick();
            check_id("stream", 16'h1000 + 16'(k), 16'(k), 1'b1);
            check_eq("stream.addr", i_address, 16'(k + 1));
        end

        // Two-cycle memory wait at pc=5
        i_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_eq("wait.busy", {15'd0, fetch_busy}, 16'h0001);
            tick();
            check_eq("wait.inst", inst_ID, 16'h0000);
            check_eq("wait.valid", {15'd0, valid_ID}, 16'h0000);
            check_eq("wait.pc", pc_ID, 16'h0004);
            check_eq("wait.addr", i_address, 16'h0005);
        end
        i_ready = 1'b1;
        #1;
        check_eq("wait.busy_end", {15'd0, fetch_busy}, 16'h0000);
        tick();
        check_id("after_wait", 16'h1005, 16'h0005, 1'b1);
        tick();
        check_id("pc6", 16'h1006, 16'h0006, 1'b1);
        check_eq("pc6.addr", i_address, 16'h0007);

        // Stall while data returns at pc=7: buffered in S_HOLD
        stall_IFID = 1'b1;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("hold.readM", {15'd0, i_readM}, 16'h0000);
            check_eq("hold.addr", i_address, 16'h0007);
            check_id("hold", 16'h1006, 16'h0006, 1'b1);
        end
        normal_inputs();
        tick();
        check_id("release", 16'h1007, 16'h0007, 1'b1);
        check_eq("release.addr", i_address, 16'h0008);
        check_eq("release.readM", {15'd0, i_readM}, 16'h0001);
        tick();
        check_id("pc8", 16'h1008, 16'h0008, 1'b1);

        // Flush + redirect with data ready at pc=9
        flush_IFID     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        tick();
        check_eq("flush.valid", {15'd0, valid_ID}, 16'h0000);
        check_eq("flush.inst", inst_ID, 16'h0000);
        check_eq("flush.addr", i_address, 16'h0040);
        normal_inputs();
        tick();
        check_id("redir", 16'h1040, 16'h0040, 1'b1);
        check_eq("redir.addr", i_address, 16'h0041);

        // Flush together with stall while in S_HOLD
        stall_IFID = 1'b1;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        tick();
        check_eq("hold2.readM", {15'd0, i_readM}, 16'h0000);
        flush_IFID = 1'b1;
        tick();
        check_eq("fs.valid", {15'd0, valid_ID}, 16'h0000);
        check_eq("fs.readM", {15'd0, i_readM}, 16'h0001);
        check_eq("fs.addr", i_address, 16'h0041);
        normal_inputs();
        tick();
        check_id("refetch", 16'h1041, 16'h0041, 1'b1);
        check_eq("refetch.addr", i_address, 16'h0042);

        // Wrap at FFFF
        flush_IFID     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        tick();
        check_eq("wrap.addr0", i_address, 16'hFFFF);
        normal_inputs();
        tick();
        check_eq("wrap.inst", inst_ID, 16'h0FFF);
        check_eq("wrap.pc", pc_ID, 16'hFFFF);
        check_eq("wrap.pc1", pc_plus1_ID, 16'h0000);
        check_eq("wrap.addr", i_address, 16'h0000);
        tick();
        check_id("pc0", 16'h1000, 16'h0000, 1'b1);

        // Reset pulse mid-wait at pc=1
        i_ready = 1'b0;
        tick();
        check_eq("mw.busy", {15'd0, fetch_busy}, 16'h0001);
        check_eq("mw.addr", i_address, 16'h0001);
        reset_n = 1'b0;
        #1;
        check_eq("ar.valid", {15'd0, valid_ID}, 16'h0000);
        check_eq("ar.pc", pc_ID, 16'h0000);
        check_eq("ar.readM", {15'd0, i_readM}, 16'h0000);
        check_eq("ar.busy", {15'd0, fetch_busy}, 16'h0000);
        check_eq("ar.addr", i_address, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        i_ready = 1'b1;
        #1;
        check_eq("ar.rel_addr", i_address, 16'h0000);
        check_eq("ar.rel_readM", {15'd0, i_readM}, 16'h0001);
        tick();
        check_id("ar.first", 16'h1000, 16'h0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
